// File: rtl/shift_reg_pkg.sv
// Shared definitions for the parallel-to-serial shift register:
// FSM state encoding and default register length.
package shift_reg_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SHIFT   = 2'b01,
      DONE_ST = 2'b10
   } state_t;

endpackage

// File: rtl/shift_reg_p2s_dff_ar.sv
// Single D flip-flop with asynchronous active-high clear; one instance per
// shift-register bit.
module dff_ar (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) q <= 1'b0;
      else     q <= d;
   end

endmodule

// File: rtl/shift_reg_p2s.sv
// Parallel-load, MSB-first serial-out shift register with frame sequencing.
//   state   | meaning
//   IDLE    | waiting for LD; Q holds
//   SHIFT   | shifting one bit per EN=1 edge, WIDTH shifts per frame
//   DONE_ST | one-cycle end-of-frame pulse; LD ignored
module shift_reg_p2s
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             C,
   input  logic             R,
   input  logic             LD,
   input  logic [WIDTH-1:0] P,
   input  logic             SI,
   input  logic             EN,
   output logic             SO,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] q_nx;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_ar u_bit (
         .clk (C),
         .clr (R),
         .d   (q_nx[i]),
         .q   (Q[i])
      );
   end

   assign SO = Q[WIDTH-1];

   // BUSY/DONE are registered from the next state so they line up with state.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state <= IDLE;
         cnt   <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         BUSY  <= (state_nx == SHIFT);
         DONE  <= (state_nx == DONE_ST);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      q_nx     = Q;
      case (state)
         IDLE: begin
            if (LD) begin
               q_nx     = P;
               cnt_nx   = '0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (EN) begin
               q_nx   = {Q[WIDTH-2:0], SI};
               cnt_nx = cnt + 1'b1;
               if (cnt == CNT_LAST) state_nx = DONE_ST;
            end
         end
         DONE_ST: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_reg_p2s.sv
// Directed bench for shift_reg_p2s: 8-bit and 4-bit instances, SO expectations
// queued at load time and popped as bits appear.
module tb_shift_reg_p2s;

   logic       C = 1'b0;
   logic       R, LD, SI, EN;
   logic [7:0] P, Q;
   logic       SO, BUSY, DONE;
   logic [3:0] p4, q4;
   logic       so4, busy4, done4;

   int   checks = 0;
   int   errors = 0;
   logic so_q[$];

   always #5 C = ~C;

   shift_reg_p2s #(.WIDTH(8)) u_dut (
      .C(C), .R(R), .LD(LD), .P(P), .SI(SI), .EN(EN),
      .SO(SO), .Q(Q), .BUSY(BUSY), .DONE(DONE)
   );

   shift_reg_p2s #(.WIDTH(4)) u_dut4 (
      .C(C), .R(R), .LD(LD), .P(p4), .SI(SI), .EN(EN),
      .SO(so4), .Q(q4), .BUSY(busy4), .DONE(done4)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_so(input logic obs);
      logic exp;
      if (so_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL so_queue: observed %0b expected <queue empty>", obs);
      end else begin
         exp = so_q.pop_front();
         chk("so", 16'(obs), 16'(exp));
      end
   endtask

   task automatic tick;
      @(posedge C);
      #1;
   endtask

   // One 8-bit frame; optional 3-cycle EN=0 stall after observation stall_at.
   task automatic run_frame8(input logic [7:0] p, input logic [7:0] si_pat,
                             input int stall_at, input bit ld_hold);
      logic [7:0] q_m;
      P  = p;
      LD = 1'b1;
      EN = 1'b1;
      SI = 1'b0;
      for (int i = 0; i < 8; i++) so_q.push_back(p[7-i]);
      tick;
      q_m = p;
      if (!ld_hold) LD = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_so(SO);
         chk("q", 16'(Q), 16'(q_m));
         chk("busy", 16'(BUSY), 16'd1);
         chk("done", 16'(DONE), 16'd0);
         if (i == stall_at) begin
            EN = 1'b0;
            for (int s = 0; s < 3; s++) begin
               SI = ~SI;
               tick;
               chk("stall_so", 16'(SO), 16'(p[7-i]));
               chk("stall_q", 16'(Q), 16'(q_m));
               chk("stall_busy", 16'(BUSY), 16'd1);
               chk("stall_done", 16'(DONE), 16'd0);
            end
            EN = 1'b1;
         end
         SI = si_pat[7-i];
         tick;
         q_m = {q_m[6:0], si_pat[7-i]};
      end
      chk("done_pulse", 16'(DONE), 16'd1);
      chk("done_busy", 16'(BUSY), 16'd0);
      chk("done_q", 16'(Q), 16'(si_pat));
      tick;
      chk("idle_done", 16'(DONE), 16'd0);
      chk("idle_busy", 16'(BUSY), 16'd0);
      chk("idle_q", 16'(Q), 16'(si_pat));
   endtask

   initial begin
      logic [3:0] pat4;
      R  = 1'b1;
      LD = 1'b0;
      EN = 1'b0;
      SI = 1'b0;
      P  = 8'h00;
      p4 = 4'h0;
      tick;
      chk("rst_q", 16'(Q), 16'h0);
      chk("rst_so", 16'(SO), 16'h0);
      chk("rst_busy", 16'(BUSY), 16'h0);
      chk("rst_done", 16'(DONE), 16'h0);
      R = 1'b0;
      P = 8'hFF;
      tick;
      chk("idle_hold_q", 16'(Q), 16'h0);
      chk("idle_hold_busy", 16'(BUSY), 16'h0);

      run_frame8(8'hA5, 8'h00, -1, 1'b0);
      run_frame8(8'hFF, 8'hB2, -1, 1'b0);
      run_frame8(8'h5A, 8'h6D, 3, 1'b0);
      // LD held: loads only on IDLE edges, frame period WIDTH+2
      run_frame8(8'h3C, 8'hC7, -1, 1'b1);
      run_frame8(8'h3C, 8'h1E, -1, 1'b1);
      LD = 1'b0;

      // Reset between edges after the 4th shift
      P  = 8'hC3;
      LD = 1'b1;
      EN = 1'b1;
      SI = 1'b1;
      for (int i = 0; i < 8; i++) so_q.push_back(P[7-i]);
      tick;
      LD = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_so(SO);
         if (i < 4) tick;
      end
      #2 R = 1'b1;
      #1;
      chk("async_q", 16'(Q), 16'h0);
      chk("async_so", 16'(SO), 16'h0);
      chk("async_busy", 16'(BUSY), 16'h0);
      chk("async_done", 16'(DONE), 16'h0);
      #1 R = 1'b0;
      so_q.delete();
      tick;
      chk("post_rst_done", 16'(DONE), 16'h0);
      chk("post_rst_busy", 16'(BUSY), 16'h0);
      chk("post_rst_q", 16'(Q), 16'h0);
      run_frame8(8'h81, 8'h5C, -1, 1'b0);

      // 4-bit instance, both reset first so it starts from IDLE
      #2 R = 1'b1;
      #1 R = 1'b0;
      pat4 = 4'h9;
      p4   = pat4;
      LD   = 1'b1;
      EN   = 1'b1;
      SI   = 1'b0;
      tick;
      LD = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("w4_so", 16'(so4), 16'(pat4[3-i]));
         chk("w4_busy", 16'(busy4), 16'd1);
         chk("w4_done", 16'(done4), 16'd0);
         tick;
      end
      chk("w4_done_pulse", 16'(done4), 16'd1);
      chk("w4_done_q", 16'(q4), 16'h0);
      tick;
      chk("w4_idle_done", 16'(done4), 16'd0);
      chk("w4_idle_busy", 16'(busy4), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
